// File: rtl/brd_wb2ps_wc_cacheram_nway.sv
`default_nettype none
// ============================================================================
// Module   : brd_wb2ps_wc_cacheram_nway
// Purpose  : N-way set-associative tag/data RAM controller for the WB<->PSRAM
//            cache bridge. Holds tags, valid/dirty bits, line data and
//            age-counter LRU state for every way. Two-cycle lookup with hit
//            compare, LRU update and write-hit byte merge, plus fill/install
//            ports for the refill engine. Runs a tag-init sweep after reset.
// Ports    : cpuclk/WSHRST  clock, synchronous active-high reset
//            init_busy      tag-init sweep in progress
//            lk_*           lookup request (valid/ready handshake)
//            rs_*           one-cycle lookup result with hit and victim info
//            fill_*         data-word write / tag install target
//            inst_*         tag install request (index taken from fill_addr)
// Revision : 1.0 - initial release
// ============================================================================
module brd_wb2ps_wc_cacheram_nway #(
    parameter int WAYS       = 4,
    parameter int LINES      = 16,
    parameter int LINE_BYTES = 64,
    parameter int ADDR_W     = 23
) (
    input  logic                                                  cpuclk,
    input  logic                                                  WSHRST,
    output logic                                                  init_busy,
    input  logic                                                  lk_valid,
    output logic                                                  lk_ready,
    input  logic [ADDR_W-1:0]                                     lk_addr,
    input  logic                                                  lk_we,
    input  logic [31:0]                                           lk_wdata,
    input  logic [3:0]                                            lk_strb,
    output logic                                                  rs_valid,
    output logic                                                  rs_hit,
    output logic [WAYS-1:0]                                       rs_way,
    output logic [31:0]                                           rs_rdata,
    output logic [WAYS-1:0]                                       rs_victim_way,
    output logic [ADDR_W-$clog2(LINES)-$clog2(LINE_BYTES)-1:0]    rs_victim_tag,
    output logic                                                  rs_victim_valid,
    output logic                                                  rs_victim_dirty,
    output logic                                                  fill_ready,
    input  logic                                                  fill_we,
    input  logic [WAYS-1:0]                                       fill_way,
    input  logic [ADDR_W-1:0]                                     fill_addr,
    input  logic [31:0]                                           fill_wdata,
    input  logic                                                  inst_valid,
    input  logic [ADDR_W-$clog2(LINES)-$clog2(LINE_BYTES)-1:0]    inst_tag,
    input  logic                                                  inst_dirty
);

    localparam int c_WS    = $clog2(WAYS);
    localparam int c_IDX_W = $clog2(LINES);
    localparam int c_OFS_W = $clog2(LINE_BYTES);
    localparam int c_TAG_W = ADDR_W - c_IDX_W - c_OFS_W;
    localparam int c_WRD_W = c_IDX_W + c_OFS_W - 2;
    localparam int c_WORDS = LINES * LINE_BYTES / 4;

    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_IDLE = 1'b1;

    // Storage
    logic [c_TAG_W-1:0] r_tag  [WAYS][LINES];
    logic               r_vld  [WAYS][LINES];
    logic               r_dty  [WAYS][LINES];
    logic [c_WS-1:0]    r_age  [WAYS][LINES];
    logic [31:0]        r_data [WAYS][c_WORDS];

    // Control / pipeline
    logic [0:0]         r_state, w_state_nxt;
    logic [c_IDX_W-1:0] r_init_idx;
    logic               r_p1_vld, r_p2_vld;
    logic [c_TAG_W-1:0] r_lk_tag;
    logic [c_IDX_W-1:0] r_lk_idx;
    logic [c_WRD_W-1:0] r_lk_wrd;
    logic               r_lk_we;
    logic [31:0]        r_lk_wdata;
    logic [3:0]         r_lk_strb;

    logic               w_inflight, w_accept, w_inst_go, w_fill_go;
    logic [WAYS-1:0]    w_hit_vec;
    logic               w_hit;
    logic [c_WS-1:0]    w_hit_sel, w_vic_sel, w_fl_sel;
    logic [31:0]        w_hit_word, w_merged;
    logic [c_IDX_W-1:0] w_fl_idx;
    logic [c_WRD_W-1:0] w_fl_wrd;

    function automatic logic [c_WS-1:0] f_lowest(input logic [WAYS-1:0] vec);
        f_lowest = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (vec[w]) f_lowest = c_WS'(w);
    endfunction

    // Age rule shared by hit and install: selected way becomes 0, ways that
    // were younger than it shift one step older, the rest keep their age.
    function automatic logic [c_WS-1:0] f_age_next(input logic [c_WS-1:0] cur,
                                                   input logic [c_WS-1:0] old,
                                                   input logic            sel);
        if (sel)            f_age_next = '0;
        else if (cur < old) f_age_next = cur + c_WS'(1);
        else                f_age_next = cur;
    endfunction

    assign init_busy  = (r_state == c_ST_INIT);
    assign w_inflight = r_p1_vld | r_p2_vld;
    assign fill_ready = !init_busy && !w_inflight;
    assign lk_ready   = fill_ready && !fill_we && !inst_valid;
    assign w_accept   = lk_valid && lk_ready;
    assign w_inst_go  = fill_ready && inst_valid && (|fill_way);
    assign w_fill_go  = fill_ready && fill_we && (|fill_way);
    assign w_fl_sel   = f_lowest(fill_way);
    assign w_fl_idx   = fill_addr[c_OFS_W +: c_IDX_W];
    assign w_fl_wrd   = fill_addr[2 +: c_WRD_W];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_INIT: if (r_init_idx == c_IDX_W'(LINES - 1)) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = r_state;
        endcase
    end

    // Hit compare and victim choice on the registered lookup index.
    always_comb begin
        w_hit_vec = '0;
        w_vic_sel = '0;
        for (int w = 0; w < WAYS; w++)
            w_hit_vec[w] = r_vld[w][r_lk_idx] && (r_tag[w][r_lk_idx] == r_lk_tag);
        for (int w = WAYS - 1; w >= 0; w--)
            if (r_age[w][r_lk_idx] == c_WS'(WAYS - 1)) w_vic_sel = c_WS'(w);
        // Invalid ways take priority over the oldest valid way.
        for (int w = WAYS - 1; w >= 0; w--)
            if (!r_vld[w][r_lk_idx]) w_vic_sel = c_WS'(w);
    end

    assign w_hit      = |w_hit_vec;
    assign w_hit_sel  = f_lowest(w_hit_vec);
    assign w_hit_word = r_data[w_hit_sel][r_lk_wrd];

    always_comb begin
        w_merged = w_hit_word;
        for (int b = 0; b < 4; b++)
            if (r_lk_strb[b]) w_merged[8*b +: 8] = r_lk_wdata[8*b +: 8];
    end

    always_ff @(posedge cpuclk) begin
        if (w_accept) begin
            r_lk_tag   <= lk_addr[ADDR_W-1 -: c_TAG_W];
            r_lk_idx   <= lk_addr[c_OFS_W +: c_IDX_W];
            r_lk_wrd   <= lk_addr[2 +: c_WRD_W];
            r_lk_we    <= lk_we;
            r_lk_wdata <= lk_wdata;
            r_lk_strb  <= lk_strb;
        end
    end

    always_ff @(posedge cpuclk) begin
        if (WSHRST) begin
            r_state         <= c_ST_INIT;
            r_init_idx      <= '0;
            r_p1_vld        <= 1'b0;
            r_p2_vld        <= 1'b0;
            rs_valid        <= 1'b0;
            rs_hit          <= 1'b0;
            rs_way          <= '0;
            rs_rdata        <= '0;
            rs_victim_way   <= '0;
            rs_victim_tag   <= '0;
            rs_victim_valid <= 1'b0;
            rs_victim_dirty <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            if (r_state == c_ST_INIT) r_init_idx <= r_init_idx + c_IDX_W'(1);
            r_p1_vld <= w_accept;
            r_p2_vld <= r_p1_vld;
            rs_valid <= r_p2_vld;
            if (r_p2_vld) begin
                rs_hit          <= w_hit;
                rs_way          <= w_hit ? (WAYS'(1) << w_hit_sel) : '0;
                rs_rdata        <= w_hit ? w_hit_word : 32'h0;
                rs_victim_way   <= WAYS'(1) << w_vic_sel;
                rs_victim_tag   <= r_tag[w_vic_sel][r_lk_idx];
                rs_victim_valid <= r_vld[w_vic_sel][r_lk_idx];
                rs_victim_dirty <= r_dty[w_vic_sel][r_lk_idx];
            end
        end
    end

    // Array writes. Install/fill only happen with no lookup in flight, so they
    // never collide with the hit-time update of the same index.
    always_ff @(posedge cpuclk) begin
        if (r_state == c_ST_INIT) begin
            for (int w = 0; w < WAYS; w++) begin
                r_vld[w][r_init_idx] <= 1'b0;
                r_dty[w][r_init_idx] <= 1'b0;
                r_tag[w][r_init_idx] <= '0;
                r_age[w][r_init_idx] <= c_WS'(WAYS - 1 - w);
            end
        end else if (!WSHRST) begin
            if (w_inst_go) begin
                for (int w = 0; w < WAYS; w++)
                    r_age[w][w_fl_idx] <= f_age_next(r_age[w][w_fl_idx],
                                                     r_age[w_fl_sel][w_fl_idx],
                                                     w_fl_sel == c_WS'(w));
                r_vld[w_fl_sel][w_fl_idx] <= 1'b1;
                r_tag[w_fl_sel][w_fl_idx] <= inst_tag;
                r_dty[w_fl_sel][w_fl_idx] <= inst_dirty;
            end
            if (w_fill_go)
                r_data[w_fl_sel][w_fl_wrd] <= fill_wdata;
            if (r_p2_vld && w_hit) begin
                for (int w = 0; w < WAYS; w++)
                    r_age[w][r_lk_idx] <= f_age_next(r_age[w][r_lk_idx],
                                                     r_age[w_hit_sel][r_lk_idx],
                                                     w_hit_sel == c_WS'(w));
                if (r_lk_we) begin
                    r_data[w_hit_sel][r_lk_wrd] <= w_merged;
                    r_dty[w_hit_sel][r_lk_idx]  <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_brd_wb2ps_wc_cacheram_nway.sv
`default_nettype none
// ============================================================================
// Module   : tb_brd_wb2ps_wc_cacheram_nway
// Purpose  : Scoreboard bench for brd_wb2ps_wc_cacheram_nway (default params).
//            Stimulus pushes expected results; a negedge monitor pops and
//            compares whenever rs_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_brd_wb2ps_wc_cacheram_nway;

    logic        cpuclk = 1'b0;
    logic        WSHRST;
    logic        init_busy, lk_valid, lk_ready, lk_we;
    logic [22:0] lk_addr;
    logic [31:0] lk_wdata;
    logic [3:0]  lk_strb;
    logic        rs_valid, rs_hit;
    logic [3:0]  rs_way, rs_victim_way;
    logic [31:0] rs_rdata;
    logic [12:0] rs_victim_tag;
    logic        rs_victim_valid, rs_victim_dirty;
    logic        fill_ready, fill_we, inst_valid, inst_dirty;
    logic [3:0]  fill_way;
    logic [22:0] fill_addr;
    logic [31:0] fill_wdata;
    logic [12:0] inst_tag;

    brd_wb2ps_wc_cacheram_nway dut (
        .cpuclk(cpuclk), .WSHRST(WSHRST), .init_busy(init_busy),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_addr(lk_addr),
        .lk_we(lk_we), .lk_wdata(lk_wdata), .lk_strb(lk_strb),
        .rs_valid(rs_valid), .rs_hit(rs_hit), .rs_way(rs_way),
        .rs_rdata(rs_rdata), .rs_victim_way(rs_victim_way),
        .rs_victim_tag(rs_victim_tag), .rs_victim_valid(rs_victim_valid),
        .rs_victim_dirty(rs_victim_dirty), .fill_ready(fill_ready),
        .fill_we(fill_we), .fill_way(fill_way), .fill_addr(fill_addr),
        .fill_wdata(fill_wdata), .inst_valid(inst_valid), .inst_tag(inst_tag),
        .inst_dirty(inst_dirty)
    );

    always #5 cpuclk = ~cpuclk;

    typedef struct {
        logic        hit;
        logic [3:0]  way;
        logic [31:0] rdata;
        logic [3:0]  vway;
        logic [12:0] vtag;
        logic        vvalid;
        logic        vdirty;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge cpuclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic h, input logic [3:0] w, input logic [31:0] d,
                                input logic [3:0] vw, input logic [12:0] vt,
                                input logic vv, input logic vd);
        exp_t e;
        e.hit = h; e.way = w; e.rdata = d; e.vway = vw; e.vtag = vt;
        e.vvalid = vv; e.vdirty = vd; e.cyc = 0;
        return e;
    endfunction

    // Monitor: every rs_valid pulse must match the oldest outstanding entry.
    always @(negedge cpuclk) begin
        if (rs_valid === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rs_valid actual=1 required=0 at cycle %0d", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("rs_latency_cycle", cyc,             mon_e.cyc);
                chk("rs_hit",           rs_hit,          mon_e.hit);
                chk("rs_way",           rs_way,          mon_e.way);
                chk("rs_rdata",         rs_rdata,        mon_e.rdata);
                chk("rs_victim_way",    rs_victim_way,   mon_e.vway);
                chk("rs_victim_tag",    rs_victim_tag,   mon_e.vtag);
                chk("rs_victim_valid",  rs_victim_valid, mon_e.vvalid);
                chk("rs_victim_dirty",  rs_victim_dirty, mon_e.vdirty);
            end
        end
    end

    // Called at a negedge; returns at a negedge once the result has been checked.
    task automatic lookup(input logic [22:0] addr, input logic we, input logic [31:0] wd,
                          input logic [3:0] st, input exp_t e);
        int n;
        lk_addr = addr; lk_we = we; lk_wdata = wd; lk_strb = st; lk_valid = 1'b1;
        #1;
        n = 0;
        while (lk_ready !== 1'b1 && n < 50) begin
            @(negedge cpuclk); #1; n++;
        end
        if (lk_ready !== 1'b1) begin
            chk("lookup_accept_timeout", lk_ready, 1);
            lk_valid = 1'b0;
            @(negedge cpuclk);
        end else begin
            e.cyc = cyc + 3;
            q.push_back(e);
            @(negedge cpuclk);
            lk_valid = 1'b0;
            n = 0;
            while (q.size() != 0 && n < 20) begin
                @(negedge cpuclk); n++;
            end
            if (q.size() != 0) begin
                chk("result_timeout", q.size(), 0);
                q.delete();
            end
        end
    endtask

    task automatic install(input logic [3:0] way, input logic [22:0] addr, input logic [12:0] tag,
                           input logic dirty, input logic do_fill, input logic [31:0] data);
        fill_way = way; fill_addr = addr; fill_wdata = data; fill_we = do_fill;
        inst_valid = 1'b1; inst_tag = tag; inst_dirty = dirty;
        #1;
        chk("install_fill_ready", fill_ready, 1);
        chk("install_blocks_lk_ready", lk_ready, 0);
        @(negedge cpuclk);
        inst_valid = 1'b0; fill_we = 1'b0; fill_way = '0;
    endtask

    // Called at the negedge where reset is released.
    task automatic count_init(output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            n++;
            @(negedge cpuclk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        WSHRST = 1'b1; lk_valid = 1'b0; lk_addr = '0; lk_we = 1'b0; lk_wdata = '0; lk_strb = '0;
        fill_we = 1'b0; fill_way = '0; fill_addr = '0; fill_wdata = '0;
        inst_valid = 1'b0; inst_tag = '0; inst_dirty = 1'b0;
        repeat (3) @(negedge cpuclk);
        chk("rst_init_busy",     init_busy,     1);
        chk("rst_lk_ready",      lk_ready,      0);
        chk("rst_fill_ready",    fill_ready,    0);
        chk("rst_rs_valid",      rs_valid,      0);
        chk("rst_rs_hit",        rs_hit,        0);
        chk("rst_rs_way",        rs_way,        0);
        chk("rst_rs_victim_way", rs_victim_way, 0);
        WSHRST = 1'b0;
        count_init(n);
        chk("init_cycles", n, 16);

        // Cold miss: all ways invalid, lowest invalid way is the victim.
        lookup(23'h000040, 1'b0, 32'h0, 4'h0, mk(1'b0, 4'b0000, 32'h0, 4'b0001, 13'h0, 1'b0, 1'b0));

        // Install + fill together, then read hit.
        install(4'b0001, 23'h001440, 13'h005, 1'b0, 1'b1, 32'h11223344);
        lookup(23'h001440, 1'b0, 32'h0, 4'h0, mk(1'b1, 4'b0001, 32'h11223344, 4'b0010, 13'h0, 1'b0, 1'b0));
        // Write hit returns pre-merge data; re-read shows merged bytes.
        lookup(23'h001440, 1'b1, 32'hAABBCCDD, 4'b0011, mk(1'b1, 4'b0001, 32'h11223344, 4'b0010, 13'h0, 1'b0, 1'b0));
        lookup(23'h001440, 1'b0, 32'h0, 4'h0, mk(1'b1, 4'b0001, 32'h1122CCDD, 4'b0010, 13'h0, 1'b0, 1'b0));

        // Fill the rest of idx1; ages become way0 oldest.
        install(4'b0010, 23'h001840, 13'h006, 1'b0, 1'b1, 32'h22222222);
        install(4'b0100, 23'h001C40, 13'h007, 1'b0, 1'b1, 32'h33333333);
        install(4'b1000, 23'h002040, 13'h008, 1'b0, 1'b1, 32'h44444444);
        lookup(23'h001840, 1'b0, 32'h0, 4'h0, mk(1'b1, 4'b0010, 32'h22222222, 4'b0001, 13'h005, 1'b1, 1'b1));
        lookup(23'h001440, 1'b0, 32'h0, 4'h0, mk(1'b1, 4'b0001, 32'h1122CCDD, 4'b0001, 13'h005, 1'b1, 1'b1));
        // After way0 hit, way2 is the oldest.
        lookup(23'h002440, 1'b0, 32'h0, 4'h0, mk(1'b0, 4'b0000, 32'h0, 4'b0100, 13'h007, 1'b1, 1'b0));

        // Reset the cycle after accept: result dropped, init re-runs, line gone.
        lk_addr = 23'h001440; lk_we = 1'b0; lk_valid = 1'b1;
        #1;
        chk("midrst_lk_ready", lk_ready, 1);
        @(negedge cpuclk);
        lk_valid = 1'b0; WSHRST = 1'b1;
        @(negedge cpuclk);
        WSHRST = 1'b0;
        count_init(n);
        chk("reinit_cycles", n, 16);
        lookup(23'h001440, 1'b0, 32'h0, 4'h0, mk(1'b0, 4'b0000, 32'h0, 4'b0001, 13'h0, 1'b0, 1'b0));

        // Same-cycle fill and lookup: fill wins, multi-hot way uses lowest bit.
        install(4'b0010, 23'h000C40, 13'h003, 1'b0, 1'b0, 32'h0);
        fill_way = 4'b1010; fill_addr = 23'h000C44; fill_wdata = 32'hCAFEF00D; fill_we = 1'b1;
        lk_addr = 23'h000C44; lk_we = 1'b0; lk_valid = 1'b1;
        #1;
        chk("fill_blocks_lk_ready", lk_ready, 0);
        @(negedge cpuclk);
        fill_we = 1'b0; fill_way = '0;
        lookup(23'h000C44, 1'b0, 32'h0, 4'h0, mk(1'b1, 4'b0010, 32'hCAFEF00D, 4'b0001, 13'h0, 1'b0, 1'b0));

        // Write miss leaves the set untouched.
        lookup(23'h001040, 1'b1, 32'hFFFFFFFF, 4'b1111, mk(1'b0, 4'b0000, 32'h0, 4'b0001, 13'h0, 1'b0, 1'b0));
        lookup(23'h000C44, 1'b0, 32'h0, 4'h0, mk(1'b1, 4'b0010, 32'hCAFEF00D, 4'b0001, 13'h0, 1'b0, 1'b0));

        repeat (4) @(negedge cpuclk);
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
